// File: rtl/branch_cmp_rv32i.sv
// rtl/branch_cmp_rv32i.sv - RV32I branch resolver with 2-entry result buffer; BR_MISALIGN_EN adds misaligned-target flag
module branch_cmp_rv32i #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_illegal,
    output logic            out_misaligned
);

    logic [1:0]      count;
    logic [1:0]      count_next;
    logic            rd_ptr;
    logic            wr_ptr;
    logic            in_ready_r;
    logic            head;
    logic            push;
    logic            pop;

    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            res_taken;
    logic            res_illegal;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_seq;
    logic [XLEN-1:0] res_next_pc;

    logic            mem_taken   [DEPTH];
    logic            mem_illegal [DEPTH];
    logic [XLEN-1:0] mem_next_pc [DEPTH];

    assign push      = in_valid && in_ready_r;
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = (count != 2'd0);

    assign cmp_eq  = (in_rs1 == in_rs2);
    assign cmp_lt  = ($signed(in_rs1) < $signed(in_rs2));
    assign cmp_ltu = (in_rs1 < in_rs2);

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (in_funct3)
            3'b000:  res_taken = cmp_eq;
            3'b001:  res_taken = !cmp_eq;
            3'b100:  res_taken = cmp_lt;
            3'b101:  res_taken = !cmp_lt;
            3'b110:  res_taken = cmp_ltu;
            3'b111:  res_taken = !cmp_ltu;
            default: res_illegal = 1'b1;
        endcase
    end

    // Both adds wrap modulo 2^XLEN; no carry is reported.
    assign res_target  = in_pc + in_imm;
    assign res_seq     = in_pc + XLEN'(4);
    assign res_next_pc = res_taken ? res_target : res_seq;

    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            count      <= count_next;
            in_ready_r <= (count_next < 2'd2);
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_taken[i]   <= 1'b0;
                mem_illegal[i] <= 1'b0;
                mem_next_pc[i] <= '0;
            end
        end else if (push) begin
            mem_taken[wr_ptr]   <= res_taken;
            mem_illegal[wr_ptr] <= res_illegal;
            mem_next_pc[wr_ptr] <= res_next_pc;
        end
    end

    // When empty, present the most recently popped slot so outputs hold their last value.
    assign head = (count == 2'd0) ? !rd_ptr : rd_ptr;

    assign out_taken   = mem_taken[head];
    assign out_illegal = mem_illegal[head];
    assign out_next_pc = mem_next_pc[head];

`ifdef BR_MISALIGN_EN
    logic mem_mis [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_mis[i] <= 1'b0;
            end
        end else if (push) begin
            mem_mis[wr_ptr] <= res_taken && (res_target[1:0] != 2'b00);
        end
    end

    assign out_misaligned = mem_mis[head];
`else
    assign out_misaligned = 1'b0;
`endif

endmodule

// File: doc/branch_cmp_rv32i.md
Name: branch_cmp_rv32i

Overview:
- Branch-resolution unit for the RV32I execute stage.
- The slt/sltu compare unit turns a comparison into a register value. This block consumes the same comparison operation and turns it into control flow: a taken/not-taken decision and a next PC.
- Accepts one conditional-branch op per handshake and resolves it with a 1-cycle registered latency.
- Results are held in a 2-entry output buffer, so fetch/writeback back-pressure never drops a resolved branch.

Parameters:
- XLEN, 32, operand/PC width; only 32 is supported.
- DEPTH, 2, output buffer entries; only 2 is supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a branch op
- in_ready  output  1  block can accept the op this cycle
- in_funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- in_rs1  input  32  first operand
- in_rs2  input  32  second operand
- in_pc  input  32  PC of the branch instruction
- in_imm  input  32  sign-extended B-type offset
- out_valid  output  1  head buffer entry is valid
- out_ready  input  1  downstream accepts the head entry
- out_taken  output  1  branch condition true
- out_next_pc  output  32  in_pc+in_imm if taken, else in_pc+4
- out_illegal  output  1  funct3 was 010 or 011
- out_misaligned  output  1  see Optional Feature

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - Buffer count = 0.
  - out_valid = 0, out_taken = 0, out_next_pc = 0, out_illegal = 0, out_misaligned = 0.
  - in_ready = 1 after reset releases.
- Reset asserted mid-operation: all entries are discarded immediately, with no partial output.
- Accept (push): in_valid && in_ready on a rising edge. The op is resolved combinationally and written to the buffer tail in that same edge.
- Latency: an op accepted at edge N appears at out_valid on edge N, so it is visible one cycle after it is presented.
- Comparisons:
  - BEQ/BNE: equality of rs1 and rs2.
  - BLT/BGE: signed two's-complement compare.
  - BLTU/BGEU: unsigned compare.
  - BGE/BGEU are the exact complements of BLT/BLTU; equal operands make BGE taken.
- Next-PC arithmetic: 32-bit modulo, wrap-around with no flag. Example: pc 0xFFFFFFFC + 4 = 0x00000000.
- Illegal funct3 (010/011):
  - out_illegal = 1, out_taken = 0, out_next_pc = pc+4.
  - The entry is still pushed and consumes a slot.
- Pop: out_valid && out_ready. The head advances and the buffer is strictly FIFO in order.
- in_ready: registered, equals (count < 2), and does not depend combinationally on out_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
  - in_ready rises on the edge after the pop.
- Simultaneous push and pop at count = 1: count stays at 1, and the new entry becomes head after the old one leaves.
- Empty buffer: out_valid = 0. Data outputs hold their last value and carry no meaning.
- Output stability: while out_valid && !out_ready, all out_* signals stay stable.
- Storage: a 2-entry circular buffer with 1-bit read/write pointers and a 2-bit count.

Optional Feature:
- Macro: BR_MISALIGN_EN.
- When defined:
  - out_misaligned = out_taken && (target[1:0] != 0), where target = pc+imm.
  - The value is stored per entry.
  - out_taken and out_next_pc are unchanged; the flag is advisory and downstream raises the exception.
- When undefined:
  - The port is still present and tied to 0.
  - No per-entry storage bit is built.

Test Plan:
- BLT rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x100, imm = 0x20 -> out_taken = 1, out_next_pc = 0x120. The same operands with BLTU -> taken = 0, next_pc = 0x104.
- BGE and BGEU with rs1 = rs2 = 0x80000000 -> both taken. BNE with the same operands -> not taken, next_pc = pc+4.
- Back-pressure: out_ready = 0, push 3 ops back-to-back -> in_ready falls after the 2nd push and the 3rd is held. Raise out_ready -> entries pop in order 1, 2, then 3 is accepted with no loss or duplication.
- funct3 = 010, pc = 0x200 -> out_illegal = 1, out_taken = 0, out_next_pc = 0x204.
- Wrap: BEQ with equal operands, pc = 0xFFFFFFF0, imm = 0x10 -> next_pc = 0x00000000. With BR_MISALIGN_EN and imm = 0x12 -> out_misaligned = 1; with the macro undefined -> 0.
- Assert rst_n low while 2 entries are pending -> out_valid = 0 immediately. After release, in_ready = 1 and the next op resolves normally.
